shift_sub_divider: RTL

Sequential restoring divider: 16-bit unsigned dividend ÷ 8-bit unsigned divisor, yielding a 16-bit quotient and an 8-bit remainder. It is the inverse of the lab's 8×8 array multiplier. It resolves one quotient bit per clock using shift-and-subtract, and uses a start/busy/done handshake. In the lab top it sits beside the multiplier. Its results feed the existing four-digit seven-segment display path, and the bench can cross-check them through the multiplier (quotient × divisor + remainder = dividend).

---
 rtl/shift_sub_divider.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor,
// one quotient bit per clock, start/busy/done handshake, divide-by-zero shortcut.
module shift_sub_divider (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic [15:0] quotient,
   output logic [7:0]  remainder,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  rem_q, rem_d;
   logic [15:0] qsh_q, qsh_d;
   logic [7:0]  dreg_q, dreg_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] quot_q, quot_d;
   logic [7:0]  remo_q, remo_d;
   logic        dz_q, dz_d;

   // The partial remainder is always below the divisor, so only the 9-bit trial
   // value needs the extra bit; the difference always fits back into 8 bits.
   logic [8:0]  trial;
   logic        ge;
   logic [7:0]  diff;
   logic [7:0]  step_rem;
   logic [15:0] step_q;

   assign trial    = {rem_q, qsh_q[15]};
   assign ge       = (trial >= {1'b0, dreg_q});
   assign diff     = trial[7:0] - dreg_q;
   assign step_rem = ge ? diff : trial[7:0];
   assign step_q   = {qsh_q[14:0], ge};

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         qsh_q   <= '0;
         dreg_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         qsh_q   <= qsh_d;
         dreg_q  <= dreg_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      qsh_d   = qsh_q;
      dreg_d  = dreg_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dz_d    = dz_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == 8'd0) begin
                  state_d = S_DONE;
                  quot_d  = 16'hFFFF;
                  remo_d  = dividend[7:0];
                  dz_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
                  rem_d   = '0;
                  qsh_d   = dividend;
                  dreg_d  = divisor;
                  cnt_d   = '0;
               end
            end
         end
         S_RUN: begin
            rem_d = step_rem;
            qsh_d = step_q;
            cnt_d = cnt_q + 4'd1;
            // Results are published on the edge that leaves RUN, so they hold through IDLE.
            if (cnt_q == 4'd15) begin
               state_d = S_DONE;
               quot_d  = step_q;
               remo_d  = step_rem;
               dz_d    = 1'b0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      quotient  = quot_q;
      remainder = remo_q;
      div_zero  = dz_q;
   end

endmodule
